// File: rtl/tqvp_htfab_anatool_mc.sv
// ============================================================================
// tqvp_htfab_anatool_mc: shared phase-accumulator time base driving
// double-buffered PWM outputs and measuring input duty cycles.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tqvp_htfab_anatool_mc #(
  parameter int NUM_IN  = 4,
  parameter int NUM_OUT = 3,
  parameter int PHASE_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam logic [3:0] ADDR_STEP_LO = 4'h8;
  localparam logic [3:0] ADDR_STEP_HI = 4'h9;
  localparam logic [3:0] ADDR_CTRL    = 4'hA;
  localparam logic [3:0] ADDR_STATUS  = 4'hC;
  localparam logic [7:0] DUTY_RESET   = 8'h80;

  logic [PHASE_W-1:0] step;
  logic [PHASE_W-1:0] tacc;
  logic [7:0]         staged;
  logic               run;
  logic               invert;
  logic               ready;
  logic               overrun;
  logic [7:0]         shadow  [NUM_OUT];
  logic [7:0]         active  [NUM_OUT];
  logic [7:0]         capture [NUM_IN];
  logic [PHASE_W-1:0] dacc    [NUM_IN];

  logic [PHASE_W:0]   tsum;
  logic [PHASE_W:0]   dsum    [NUM_IN];
  logic               wrap;
  logic [7:0]         top8;
  logic [15:0]        step_wr;
  logic [15:0]        step_rd;
  logic [NUM_OUT-1:0] pwm;
  logic               status_wr;
  logic               unused_in;

  assign tsum      = {1'b0, tacc} + {1'b0, step};
  assign wrap      = run & tsum[PHASE_W];
  assign top8      = tacc[PHASE_W-1 -: 8];
  assign step_wr   = {data_in, staged};
  assign step_rd   = 16'(step);
  assign status_wr = data_write && (address == ADDR_STATUS);
  assign unused_in = ^ui_in;

  always_comb begin
    for (int j = 0; j < NUM_IN; j++) begin
      dsum[j] = {1'b0, dacc[j]} + (ui_in[j] ? {1'b0, step} : '0);
    end
  end

  // Stopped time base forces every output low regardless of invert.
  generate
    for (genvar i = 0; i < NUM_OUT; i++) begin : g_pwm
      assign pwm[i] = run & ((top8 < active[i]) ^ invert);
    end
  endgenerate

  always_comb begin
    uo_out = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      uo_out[i+1] = pwm[i];
    end
  end

  always_comb begin
    data_out = '0;
    case (address)
      ADDR_STEP_LO: data_out = staged;
      ADDR_STEP_HI: data_out = step_rd[15:8];
      ADDR_CTRL:    data_out = {6'b0, invert, run};
      ADDR_STATUS:  data_out = {6'b0, overrun, ready};
      default: begin
        for (int j = 0; j < NUM_IN; j++) begin
          if (address == 4'(j)) data_out = capture[j];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step    <= '0;
      tacc    <= '0;
      staged  <= '0;
      run     <= 1'b1;
      invert  <= 1'b0;
      ready   <= 1'b0;
      overrun <= 1'b0;
      for (int i = 0; i < NUM_OUT; i++) begin
        shadow[i] <= DUTY_RESET;
        active[i] <= DUTY_RESET;
      end
      for (int j = 0; j < NUM_IN; j++) begin
        capture[j] <= '0;
        dacc[j]    <= '0;
      end
    end else begin
      if (data_write) begin
        case (address)
          ADDR_STEP_LO: staged <= data_in;
          ADDR_STEP_HI: step   <= step_wr[PHASE_W-1:0];
          ADDR_CTRL: begin
            run    <= data_in[0];
            invert <= data_in[1];
          end
          default: begin
            for (int i = 0; i < NUM_OUT; i++) begin
              if (address == 4'(i)) shadow[i] <= data_in;
            end
          end
        endcase
      end

      // Clears come first so that a wrap in the same cycle wins.
      if (status_wr && data_in[0]) ready   <= 1'b0;
      if (status_wr && data_in[1]) overrun <= 1'b0;
      if (wrap) begin
        ready <= 1'b1;
        if (ready) overrun <= 1'b1;
      end

      if (run) begin
        tacc <= tsum[PHASE_W-1:0];
        for (int j = 0; j < NUM_IN; j++) begin
          if (wrap) begin
            capture[j] <= dsum[j][PHASE_W] ? 8'hFF : dsum[j][PHASE_W-1 -: 8];
            dacc[j]    <= '0;
          end else begin
            dacc[j] <= dsum[j][PHASE_W-1:0];
          end
        end
        if (wrap) begin
          for (int i = 0; i < NUM_OUT; i++) active[i] <= shadow[i];
        end
      end else begin
        tacc <= '0;
        for (int j = 0; j < NUM_IN; j++) dacc[j] <= '0;
        for (int i = 0; i < NUM_OUT; i++) active[i] <= shadow[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tqvp_htfab_anatool_mc.sv
// Directed bench for tqvp_htfab_anatool_mc: PWM duty, period, capture and status behaviour.
`default_nettype none

module tb_tqvp_htfab_anatool_mc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ui_in = '0;
  logic [7:0] uo_out;
  logic [3:0] address = '0;
  logic       data_write = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit pat_en = 1'b0;

  tqvp_htfab_anatool_mc #(.NUM_IN(4), .NUM_OUT(3), .PHASE_W(16)) dut (
    .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out), .address(address),
    .data_write(data_write), .data_in(data_in), .data_out(data_out)
  );

  always #10 clk = ~clk;

  // Input pattern: in0 high, in1 low, in2 toggles, in3 high 4 of every 16 cycles.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (pat_en) ui_in = {4'b0, (cyc[3:0] < 4'd4), cyc[0], 1'b0, 1'b1};
    else        ui_in = '0;
  end

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    address = a; data_in = d; data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] v);
    address = a;
    #1;
    v = data_out;
  endtask

  task automatic count_high(input int bitn, input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      if (uo_out[bitn]) c++;
      @(negedge clk);
    end
  endtask

  task automatic measure_period(output int pmin, output int pmax);
    logic prev;
    int cnt, edges;
    pmin = 1000; pmax = -1; edges = 0; cnt = 0;
    prev = uo_out[1];
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cnt++;
      if (uo_out[1] && !prev) begin
        if (edges > 0) begin
          if (cnt < pmin) pmin = cnt;
          if (cnt > pmax) pmax = cnt;
        end
        edges++;
        cnt = 0;
        if (edges == 5) break;
      end
      prev = uo_out[1];
    end
  endtask

  task automatic wait_ready(output bit ok);
    logic [7:0] v;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      rd(4'hC, v);
      if (v[0]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    do_reset();
    rd(4'h0, v); total++;
    if (v !== 8'h00) begin bad++; $display("FAIL reset_cap0 got=%h exp=00", v); end
    rd(4'hC, v); total++;
    if (v !== 8'h00) begin bad++; $display("FAIL reset_status got=%h exp=00", v); end
    rd(4'hA, v); total++;
    if (v !== 8'h01) begin bad++; $display("FAIL reset_ctrl got=%h exp=01", v); end
    total++;
    if (uo_out !== 8'h0E) begin bad++; $display("FAIL reset_uo got=%h exp=0e", uo_out); end
  endtask

  task automatic test_pwm();
    int s0, c, c1, c2, pmin, pmax;
    wr(4'h8, 8'h00);
    wr(4'h9, 8'h10);
    s0 = int'(uo_out[1]);
    wr(4'h0, 8'h40);
    count_high(1, 14, c);
    total++;
    if (s0 + c !== 8) begin bad++; $display("FAIL pwm_prewrap_50 got=%0d exp=8", s0 + c); end
    repeat (20) @(negedge clk);
    c = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < 16; i++) begin
      c += int'(uo_out[1]); c1 += int'(uo_out[2]); c2 += int'(uo_out[3]);
      @(negedge clk);
    end
    total++;
    if (c !== 4) begin bad++; $display("FAIL pwm0_duty40 got=%0d exp=4", c); end
    total++;
    if (c1 !== 8 || c2 !== 8) begin bad++; $display("FAIL pwm12_duty80 got=%0d,%0d exp=8,8", c1, c2); end
    measure_period(pmin, pmax);
    total++;
    if (pmin !== 16 || pmax !== 16) begin bad++; $display("FAIL period16 got=%0d..%0d exp=16", pmin, pmax); end
    wr(4'h8, 8'h55);
    measure_period(pmin, pmax);
    total++;
    if (pmin !== 16 || pmax !== 16) begin bad++; $display("FAIL period_staged_only got=%0d..%0d exp=16", pmin, pmax); end
    wr(4'h2, 8'h00);
    repeat (20) @(negedge clk);
    count_high(3, 16, c);
    total++;
    if (c !== 0) begin bad++; $display("FAIL duty00 got=%0d exp=0", c); end
    wr(4'h8, 8'h00);
    wr(4'h9, 8'h01);
    wr(4'h2, 8'hFF);
    repeat (300) @(negedge clk);
    count_high(3, 256, c);
    total++;
    if (c !== 255) begin bad++; $display("FAIL dutyFF got=%0d exp=255", c); end
  endtask

  task automatic check_caps(input string tag);
    logic [7:0] v;
    logic [7:0] exp [4];
    exp[0] = 8'hFF; exp[1] = 8'h00; exp[2] = 8'h80; exp[3] = 8'h40;
    for (int j = 0; j < 4; j++) begin
      rd(4'(j), v); total++;
      if (v !== exp[j]) begin bad++; $display("FAIL %s_cap%0d got=%h exp=%h", tag, j, v, exp[j]); end
    end
  endtask

  task automatic test_measure();
    logic [7:0] v;
    bit ok;
    do_reset();
    pat_en = 1'b1;
    wr(4'h8, 8'h00);
    wr(4'h9, 8'h10);
    wait_ready(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL measure_ready_timeout got=0 exp=1"); end
    check_caps("measure");
    rd(4'hC, v); total++;
    if (v !== 8'h01) begin bad++; $display("FAIL measure_status got=%h exp=01", v); end
  endtask

  task automatic test_status();
    logic [7:0] v;
    repeat (16) @(negedge clk);
    rd(4'hC, v); total++;
    if (v !== 8'h03) begin bad++; $display("FAIL status_overrun got=%h exp=03", v); end
    wr(4'hC, 8'h03);
    rd(4'hC, v); total++;
    if (v !== 8'h00) begin bad++; $display("FAIL status_clear got=%h exp=00", v); end
    repeat (14) @(negedge clk);
    wr(4'hC, 8'h03);
    rd(4'hC, v); total++;
    if (v !== 8'h01) begin bad++; $display("FAIL status_clear_on_wrap got=%h exp=01", v); end
  endtask

  task automatic test_stop_invert();
    logic [7:0] v;
    int c0, c1, c2;
    wr(4'hA, 8'h00);
    total++;
    if (uo_out !== 8'h00) begin bad++; $display("FAIL stop_uo got=%h exp=00", uo_out); end
    wr(4'h1, 8'h20);
    wr(4'hA, 8'h02);
    total++;
    if (uo_out !== 8'h00) begin bad++; $display("FAIL stop_invert_ignored got=%h exp=00", uo_out); end
    rd(4'hA, v); total++;
    if (v !== 8'h02) begin bad++; $display("FAIL ctrl_read got=%h exp=02", v); end
    repeat (40) @(negedge clk);
    rd(4'hC, v); total++;
    if (v !== 8'h01) begin bad++; $display("FAIL stop_status_frozen got=%h exp=01", v); end
    check_caps("stop");
    wr(4'hA, 8'h03);
    c0 = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < 16; i++) begin
      c0 += int'(uo_out[1]); c1 += int'(uo_out[2]); c2 += int'(uo_out[3]);
      @(negedge clk);
    end
    total++;
    if (c1 !== 14) begin bad++; $display("FAIL invert_pwm1 got=%0d exp=14", c1); end
    total++;
    if (c0 !== 8 || c2 !== 8) begin bad++; $display("FAIL invert_pwm02 got=%0d,%0d exp=8,8", c0, c2); end
  endtask

  task automatic test_reset_midwindow();
    logic [7:0] v;
    bit ok;
    wr(4'hA, 8'h01);
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (uo_out !== 8'h0E) begin bad++; $display("FAIL midrst_uo got=%h exp=0e", uo_out); end
    for (int j = 0; j < 4; j++) begin
      rd(4'(j), v); total++;
      if (v !== 8'h00) begin bad++; $display("FAIL midrst_cap%0d got=%h exp=00", j, v); end
    end
    rd(4'hC, v); total++;
    if (v !== 8'h00) begin bad++; $display("FAIL midrst_status got=%h exp=00", v); end
    rd(4'h9, v); total++;
    if (v !== 8'h00) begin bad++; $display("FAIL midrst_step got=%h exp=00", v); end
    repeat (5) @(negedge clk);
    wr(4'h8, 8'h00);
    wr(4'h9, 8'h10);
    wait_ready(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL midrst_ready_timeout got=0 exp=1"); end
    check_caps("fresh");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_pwm();
    test_measure();
    test_status();
    test_stop_invert();
    test_reset_midwindow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
